// File: rtl/button_debouncer_array.sv
// Multi-channel push-button debouncer: synchroniser, tick-based stability filter,
// and per-channel hold FSM emitting press/release/long/repeat pulses.
module button_debouncer_array #(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 128000,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 250,
  parameter int REPEAT_TICKS = 25,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_buttons,
  output logic [CHANNELS-1:0] o_state,
  output logic [CHANNELS-1:0] o_press,
  output logic [CHANNELS-1:0] o_release,
  output logic [CHANNELS-1:0] o_long,
  output logic [CHANNELS-1:0] o_repeat
);

  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SC_W     = $clog2(STABLE_TICKS + 1);
  localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HC_W     = $clog2(HOLD_MAX + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;

  // Pin level of a released button; also the XOR mask that maps pins to "pressed".
  localparam logic [CHANNELS-1:0] REL_LEVEL = {CHANNELS{ACTIVE_LOW != 0}};

  logic [DIV_W-1:0]    r_div;
  logic                w_tick;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] w_level;

  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= REL_LEVEL;
      r_sync2 <= REL_LEVEL;
    end else begin
      r_sync1 <= i_buttons;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = r_sync2 ^ REL_LEVEL;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [SC_W-1:0] r_scnt;
      logic [HC_W-1:0] r_hcnt;
      logic [1:0]      r_fsm;
      logic            r_state;
      logic            r_press;
      logic            r_release;
      logic            r_long;
      logic            r_repeat;
      logic            w_accept;
      logic            w_acc_press;
      logic            w_acc_release;
      logic            w_long_hit;
      logic            w_rep_hit;

      assign w_accept      = (w_level[gi] != r_state) && w_tick &&
                             (r_scnt == SC_W'(STABLE_TICKS - 1));
      assign w_acc_press   = w_accept && w_level[gi];
      assign w_acc_release = w_accept && !w_level[gi];
      assign w_long_hit    = (r_fsm == S_PRESSED) && w_tick &&
                             (r_hcnt == HC_W'(LONG_TICKS - 1));
      assign w_rep_hit     = (REPEAT_TICKS != 0) && (r_fsm == S_HELD) && w_tick &&
                             (r_hcnt == HC_W'(REPEAT_TICKS - 1));

      // A single agreeing cycle restarts the filter, even between ticks.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_state   <= 1'b0;
          r_scnt    <= '0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= w_acc_press;
          r_release <= w_acc_release;
          if (w_level[gi] == r_state) begin
            r_scnt <= '0;
          end else if (w_tick) begin
            if (w_accept) begin
              r_state <= w_level[gi];
              r_scnt  <= '0;
            end else begin
              r_scnt <= r_scnt + SC_W'(1);
            end
          end
        end
      end

      // A release accepted on the same edge suppresses any long/repeat pulse.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_fsm    <= S_IDLE;
          r_hcnt   <= '0;
          r_long   <= 1'b0;
          r_repeat <= 1'b0;
        end else begin
          r_long   <= w_long_hit && !w_acc_release;
          r_repeat <= w_rep_hit && !w_acc_release;
          if (w_acc_release) begin
            r_fsm  <= S_IDLE;
            r_hcnt <= '0;
          end else begin
            case (r_fsm)
              S_IDLE: begin
                if (w_acc_press) begin
                  r_fsm  <= S_PRESSED;
                  r_hcnt <= '0;
                end
              end
              S_PRESSED: begin
                if (w_long_hit) begin
                  r_fsm  <= S_HELD;
                  r_hcnt <= '0;
                end else if (w_tick) begin
                  r_hcnt <= r_hcnt + HC_W'(1);
                end
              end
              S_HELD: begin
                if (w_rep_hit) begin
                  r_hcnt <= '0;
                end else if (w_tick && (REPEAT_TICKS != 0)) begin
                  r_hcnt <= r_hcnt + HC_W'(1);
                end
              end
              default: begin
                r_fsm  <= S_IDLE;
                r_hcnt <= '0;
              end
            endcase
          end
        end
      end

      assign o_state[gi]   = r_state;
      assign o_press[gi]   = r_press;
      assign o_release[gi] = r_release;
      assign o_long[gi]    = r_long;
      assign o_repeat[gi]  = r_repeat;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer_array.sv
// Bench for button_debouncer_array: two configurations driven with the same logical
// button activity, checked every cycle against a tick-counting reference model.
module tb_button_debouncer_array;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LG = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] p = 2'b00;
  logic [1:0] pins_a;
  logic [1:0] pins_b;
  logic [1:0] o_state_a, o_press_a, o_release_a, o_long_a, o_repeat_a;
  logic [1:0] o_state_b, o_press_b, o_release_b, o_long_b, o_repeat_b;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;
  int cyc = 0;

  assign pins_a = ~p;
  assign pins_b = p;

  always #5 clk = ~clk;

  button_debouncer_array #(
    .CHANNELS(2), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LG),
    .REPEAT_TICKS(2), .ACTIVE_LOW(1)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_buttons(pins_a),
    .o_state(o_state_a), .o_press(o_press_a), .o_release(o_release_a),
    .o_long(o_long_a), .o_repeat(o_repeat_a)
  );

  button_debouncer_array #(
    .CHANNELS(2), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LG),
    .REPEAT_TICKS(0), .ACTIVE_LOW(0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_buttons(pins_b),
    .o_state(o_state_b), .o_press(o_press_b), .o_release(o_release_b),
    .o_long(o_long_b), .o_repeat(o_repeat_b)
  );

  // ---------------- reference model ----------------
  int         al[2] = '{1, 0};
  int         rp[2] = '{2, 0};
  int         m_cyc;
  logic [1:0] m_s1[2], m_s2[2];
  logic [1:0] m_state[2], m_press[2], m_rel[2], m_long[2], m_rep[2];
  int         m_dis[2][2];
  int         m_held[2][2];

  task automatic model_reset();
    m_cyc = 0;
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = (al[d] != 0) ? 2'b11 : 2'b00;
      m_s2[d] = m_s1[d];
      m_state[d] = 2'b00; m_press[d] = 2'b00; m_rel[d] = 2'b00;
      m_long[d] = 2'b00;  m_rep[d] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        m_dis[d][c] = 0;
        m_held[d][c] = -1;
      end
    end
  endtask

  task automatic model_step();
    logic       tk;
    logic [1:0] lvl;
    logic       acc_p, acc_r;
    tk = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    for (int d = 0; d < 2; d++) begin
      lvl = m_s2[d] ^ ((al[d] != 0) ? 2'b11 : 2'b00);
      m_s2[d] = m_s1[d];
      m_s1[d] = (d == 0) ? pins_a : pins_b;
      m_press[d] = 2'b00; m_rel[d] = 2'b00; m_long[d] = 2'b00; m_rep[d] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        acc_p = 1'b0;
        acc_r = 1'b0;
        // Disagreeing ticks since the last agreeing cycle.
        if (lvl[c] == m_state[d][c]) begin
          m_dis[d][c] = 0;
        end else if (tk) begin
          m_dis[d][c]++;
          if (m_dis[d][c] == ST) begin
            m_state[d][c] = lvl[c];
            m_dis[d][c] = 0;
            if (lvl[c]) acc_p = 1'b1; else acc_r = 1'b1;
          end
        end
        m_press[d][c] = acc_p;
        m_rel[d][c] = acc_r;
        // Ticks elapsed since the accepted press; -1 while released.
        if (acc_p) begin
          m_held[d][c] = 0;
        end else if (acc_r) begin
          m_held[d][c] = -1;
        end else if (m_held[d][c] >= 0 && tk) begin
          m_held[d][c]++;
          if (m_held[d][c] == LG)
            m_long[d][c] = 1'b1;
          else if (m_held[d][c] > LG && rp[d] != 0 && ((m_held[d][c] - LG) % rp[d]) == 0)
            m_rep[d][c] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [9:0] got, exp;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      got = (d == 0) ? {o_state_a, o_press_a, o_release_a, o_long_a, o_repeat_a}
                     : {o_state_b, o_press_b, o_release_b, o_long_b, o_repeat_b};
      exp = rst_n ? {m_state[d], m_press[d], m_rel[d], m_long[d], m_rep[d]} : 10'd0;
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        if (n_print < 30) begin
          n_print++;
          $display("FAIL model_cmp dut%0d cycle %0d: got state/press/rel/long/rep=%b required %b",
                   d, cyc, got, exp);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end else begin
      $display("check %s = %0d ok", nm, got);
    end
  endtask

  task automatic check_rng(input string nm, input int got, input int lo, input int hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d..%0d", nm, got, lo, hi);
    end else begin
      $display("check %s = %0d ok", nm, got);
    end
  endtask

  function automatic logic [1:0] sel_a(input int kind);
    case (kind)
      0: sel_a = o_press_a;
      1: sel_a = o_release_a;
      2: sel_a = o_long_a;
      default: sel_a = o_repeat_a;
    endcase
  endfunction

  task automatic wait_pulse(input int kind, input int ch, input int bound,
                            input string nm, output int at);
    bit   done;
    logic [1:0] v;
    done = 1'b0;
    at = -100000;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      v = sel_a(kind);
      if (v[ch]) begin
        at = cyc;
        done = 1'b1;
        $display("event %s ch%0d at cycle %0d", nm, ch, cyc);
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no pulse within %0d cycles, required one", nm, bound);
    end
  endtask

  task automatic idle_cycles(input int n, output int seen_any, output int seen_lr);
    seen_any = 0;
    seen_lr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (|{o_press_a, o_release_a, o_long_a, o_repeat_a, o_press_b, o_release_b,
            o_long_b, o_repeat_b}) seen_any = 1;
      if (|{o_long_a, o_repeat_a, o_long_b, o_repeat_b}) seen_lr = 1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, tp, tl, tr, any, lr, seen;
    int runlen[2];

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Released pins after reset: no events, state stays 0.
    idle_cycles(100, any, lr);
    check_eq("idle_no_pulse", any, 0);
    check_eq("idle_state_a", int'(o_state_a), 0);

    // Bounce of 5-cycle segments never spans three ticks.
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      p[0] = ~p[0];
      repeat (5) begin
        @(negedge clk);
        if (o_press_a[0] || o_press_b[0]) seen = 1;
      end
    end
    p[0] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_press_a[0] || o_press_b[0]) seen = 1;
    end
    check_eq("bounce_no_press", seen, 0);
    check_eq("bounce_state", int'(o_state_a[0]), 0);

    // Clean press, long press, repeats, release.
    p[0] = 1'b1;
    t0 = cyc;
    wait_pulse(0, 0, 40, "press", tp);
    check_rng("press_latency", tp - t0, 11, 14);
    check_eq("press_state", int'(o_state_a[0]), 1);
    wait_pulse(2, 0, 40, "long", tl);
    check_eq("long_delay", tl - tp, 20);
    wait_pulse(3, 0, 20, "repeat1", tr);
    check_eq("repeat1_delay", tr - tp, 28);
    wait_pulse(3, 0, 20, "repeat2", tr);
    check_eq("repeat2_delay", tr - tp, 36);
    p[0] = 1'b0;
    t0 = cyc;
    wait_pulse(1, 0, 40, "release", tr);
    check_rng("release_latency", tr - t0, 11, 14);
    idle_cycles(60, any, lr);
    check_eq("after_release_quiet", lr, 0);

    // Release whose acceptance lands on the long-press tick.
    p[0] = 1'b1;
    wait_pulse(0, 0, 40, "press", tp);
    repeat (7) @(negedge clk);
    p[0] = 1'b0;
    wait_pulse(1, 0, 30, "release", tr);
    check_eq("release_on_long_tick", tr - tp, 20);
    idle_cycles(40, any, lr);
    check_eq("no_long_on_release", lr, 0);

    // Both channels together, then ch1 re-pressed while ch0 repeats.
    p = 2'b11;
    wait_pulse(0, 0, 40, "press", tp);
    check_eq("dual_press_a", int'(o_press_a), 3);
    check_eq("dual_press_b", int'(o_press_b), 3);
    repeat (5) @(negedge clk);
    p[1] = 1'b0;
    wait_pulse(3, 0, 60, "repeat", tr);
    p[1] = 1'b1;
    repeat (80) @(negedge clk);

    // Asynchronous reset mid-press clears outputs before the next edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset_clear", int'({o_state_a, o_press_a, o_release_a, o_long_a,
                                           o_repeat_a, o_state_b, o_repeat_b}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    wait_pulse(0, 0, 40, "press_after_reset", tp);
    check_rng("press_after_reset_latency", tp - t0, 11, 14);
    p = 2'b00;
    repeat (40) @(negedge clk);

    // Randomised activity: mixture of bounces and genuine holds.
    runlen[0] = 1;
    runlen[1] = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        runlen[c]--;
        if (runlen[c] <= 0) begin
          p[c] = ~p[c];
          runlen[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                                  : int'($urandom_range(10, 80));
        end
      end
    end
    p = 2'b00;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
